// File: rtl/alu_seq.sv
// Registered, valid/ready handshaked ALU with iterative shift-add multiply and restoring divide.
// Optional feature macro: ALU_MULH_EN (opcode 14 returns the upper half of the signed product).
module alu_seq #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carryout,
    output logic             overflow,
    output logic             div_by_zero,
    output logic             busy
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_NAND = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_ADD  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;
    localparam logic [3:0] OP_DIV  = 4'd10;
    localparam logic [3:0] OP_MOD  = 4'd11;
    localparam logic [3:0] OP_SLA  = 4'd12;
    localparam logic [3:0] OP_SRA  = 4'd13;
`ifdef ALU_MULH_EN
    localparam logic [3:0] OP_MULH = 4'd14;
`endif

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_iter(input logic [3:0] op);
        case (op)
            OP_MUL, OP_DIV, OP_MOD: is_iter = 1'b1;
`ifdef ALU_MULH_EN
            OP_MULH:                is_iter = 1'b1;
`endif
            default:                is_iter = 1'b0;
        endcase
    endfunction

    state_t                 state_r;
    logic [WIDTH-1:0]       a_r, b_r;
    logic [3:0]             op_r;
    logic [SHW:0]           cnt_r;
    logic [2*WIDTH-1:0]     p_r, mc_r;
    logic [WIDTH:0]         mp_r, d_r;
    logic [WIDTH-1:0]       rem_r, q_r;
    logic [WIDTH-1:0]       result_r;
    logic                   zero_r, negative_r, carryout_r, overflow_r, dbz_r;
    logic                   out_valid_r, busy_r;

    logic                   in_ready_s, accept_s;
    logic [SHW-1:0]         shamt_s;
    logic [WIDTH:0]         sum_s, diff_s, mag_a_s, mag_b_s, rem_sh_s;
    logic                   rem_take_s;
    logic [WIDTH-1:0]       sc_res_s;
    logic                   sc_cout_s, sc_ovf_s, sc_flag_en_s;
    logic                   prod_neg_s, b_zero_s;
    logic [2*WIDTH-1:0]     prod_full_s;
    logic [WIDTH-1:0]       fix_res_s;
    logic                   fix_ovf_s, fix_dbz_s;

    assign in_ready_s = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign shamt_s    = b[SHW-1:0];
    assign sum_s      = {1'b0, a} + {1'b0, b};
    assign diff_s     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    // Magnitudes carry one extra bit so the most-negative operand stays positive.
    assign mag_a_s    = a[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {a[WIDTH-1], a}) : {a[WIDTH-1], a};
    assign mag_b_s    = b[WIDTH-1] ? ({(WIDTH+1){1'b0}} - {b[WIDTH-1], b}) : {b[WIDTH-1], b};
    assign rem_sh_s   = {rem_r, q_r[WIDTH-1]};
    assign rem_take_s = (rem_sh_s >= d_r);

    // Single-cycle datapath evaluated on the operands being accepted.
    always_comb begin
        sc_res_s     = {WIDTH{1'b0}};
        sc_cout_s    = 1'b0;
        sc_ovf_s     = 1'b0;
        sc_flag_en_s = 1'b1;
        case (opcode)
            OP_AND:  sc_res_s = a & b;
            OP_OR:   sc_res_s = a | b;
            OP_XOR:  sc_res_s = a ^ b;
            OP_NOR:  sc_res_s = ~(a | b);
            OP_NAND: sc_res_s = ~(a & b);
            OP_NOT:  sc_res_s = ~a;
            OP_ADD: begin
                sc_res_s  = sum_s[WIDTH-1:0];
                sc_cout_s = sum_s[WIDTH];
                sc_ovf_s  = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_s  = diff_s[WIDTH-1:0];
                sc_cout_s = diff_s[WIDTH];
                sc_ovf_s  = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLT: begin
                if ($signed(a) < $signed(b)) begin
                    sc_res_s = {{(WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    sc_res_s = {WIDTH{1'b0}};
                end
            end
            OP_SLA:  sc_res_s = a << shamt_s;
            OP_SRA:  sc_res_s = $signed(a) >>> shamt_s;
            default: sc_flag_en_s = 1'b0;
        endcase
    end

    // Sign fixup applied to the magnitude results in the last BUSY cycle.
    always_comb begin
        prod_neg_s  = a_r[WIDTH-1] ^ b_r[WIDTH-1];
        prod_full_s = prod_neg_s ? ({(2*WIDTH){1'b0}} - p_r) : p_r;
        b_zero_s    = (b_r == {WIDTH{1'b0}});
        fix_res_s   = {WIDTH{1'b0}};
        fix_ovf_s   = 1'b0;
        fix_dbz_s   = 1'b0;
        case (op_r)
            OP_MUL: begin
                fix_res_s = prod_full_s[WIDTH-1:0];
                fix_ovf_s = (prod_full_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_full_s[WIDTH-1]}});
            end
            OP_DIV: begin
                if (b_zero_s) begin
                    fix_res_s = {WIDTH{1'b1}};
                    fix_dbz_s = 1'b1;
                end else begin
                    fix_res_s = prod_neg_s ? ({WIDTH{1'b0}} - q_r) : q_r;
                    fix_ovf_s = (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}});
                end
            end
            OP_MOD: begin
                if (b_zero_s) begin
                    fix_res_s = a_r;
                    fix_dbz_s = 1'b1;
                end else begin
                    fix_res_s = a_r[WIDTH-1] ? ({WIDTH{1'b0}} - rem_r) : rem_r;
                end
            end
`ifdef ALU_MULH_EN
            OP_MULH: fix_res_s = prod_full_s[2*WIDTH-1:WIDTH];
`endif
            default: fix_res_s = {WIDTH{1'b0}};
        endcase
    end

    // Control FSM, iterative datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            op_r        <= 4'd0;
            cnt_r       <= {(SHW+1){1'b0}};
            p_r         <= {(2*WIDTH){1'b0}};
            mc_r        <= {(2*WIDTH){1'b0}};
            mp_r        <= {(WIDTH+1){1'b0}};
            d_r         <= {(WIDTH+1){1'b0}};
            rem_r       <= {WIDTH{1'b0}};
            q_r         <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            negative_r  <= 1'b0;
            carryout_r  <= 1'b0;
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        a_r   <= a;
                        b_r   <= b;
                        op_r  <= opcode;
                        cnt_r <= {(SHW+1){1'b0}};
                        p_r   <= {(2*WIDTH){1'b0}};
                        mc_r  <= {{(WIDTH-1){1'b0}}, mag_a_s};
                        mp_r  <= mag_b_s;
                        d_r   <= mag_b_s;
                        rem_r <= {WIDTH{1'b0}};
                        q_r   <= mag_a_s[WIDTH-1:0];
                        if (is_iter(opcode)) begin
                            state_r     <= BUSY;
                            busy_r      <= 1'b1;
                            out_valid_r <= 1'b0;
                        end else begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= sc_res_s;
                            zero_r      <= sc_flag_en_s && (sc_res_s == {WIDTH{1'b0}});
                            negative_r  <= sc_res_s[WIDTH-1];
                            carryout_r  <= sc_cout_s;
                            overflow_r  <= sc_ovf_s;
                            dbz_r       <= 1'b0;
                        end
                    end else if ((state_r == DONE) && out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt_r != CNT_LAST) begin
                        if (mp_r[0]) begin
                            p_r <= p_r + mc_r;
                        end
                        mc_r  <= {mc_r[2*WIDTH-2:0], 1'b0};
                        mp_r  <= {1'b0, mp_r[WIDTH:1]};
                        rem_r <= rem_take_s ? WIDTH'(rem_sh_s - d_r) : rem_sh_s[WIDTH-1:0];
                        q_r   <= {q_r[WIDTH-2:0], rem_take_s};
                        cnt_r <= cnt_r + {{SHW{1'b0}}, 1'b1};
                    end else begin
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                        cnt_r       <= {(SHW+1){1'b0}};
                        result_r    <= fix_res_s;
                        zero_r      <= (fix_res_s == {WIDTH{1'b0}});
                        negative_r  <= fix_res_s[WIDTH-1];
                        carryout_r  <= 1'b0;
                        overflow_r  <= fix_ovf_s;
                        dbz_r       <= fix_dbz_s;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    busy_r      <= 1'b0;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_s;
    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign zero        = zero_r;
    assign negative    = negative_r;
    assign carryout    = carryout_r;
    assign overflow    = overflow_r;
    assign div_by_zero = dbz_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32: vector table plus handshake, stall and reset sequences.
module tb_alu_seq;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [4:0]   fl;   // {zero, negative, carryout, overflow, div_by_zero}
    } vec_t;

    logic         clk, reset, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic [3:0]   opcode;
    logic         zero, negative, carryout, overflow, div_by_zero, busy;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .negative(negative), .carryout(carryout),
        .overflow(overflow), .div_by_zero(div_by_zero), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] op);
        if (op == 4'd9 || op == 4'd10 || op == 4'd11) return W + 1;
`ifdef ALU_MULH_EN
        if (op == 4'd14) return W + 1;
`endif
        return 0;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int busy_cnt;
        check($sformatf("vec%0d_in_ready", idx), {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        a        = v.a;
        b        = v.b;
        opcode   = v.op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        opcode   = 4'($urandom);
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        while (!out_valid && lat < 200) begin
            if (busy) busy_cnt++;
            lat++;
            @(negedge clk);
        end
        check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(exp_lat(v.op)));
        check($sformatf("vec%0d_busy_cycles", idx), 64'(busy_cnt), 64'(exp_lat(v.op)));
        check($sformatf("vec%0d_result", idx), {32'd0, result}, {32'd0, v.res});
        check($sformatf("vec%0d_flags", idx),
              {59'd0, zero, negative, carryout, overflow, div_by_zero}, {59'd0, v.fl});
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        opcode    = 4'd0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {21'd0, out_valid, busy, zero, negative, carryout, overflow, div_by_zero, result},
              64'd0);
        check("reset_in_ready", {63'd0, in_ready}, 64'd1);
        reset = 1'b0;
        @(negedge clk);

        //              op     a             b             result        {z,n,c,v,d}
        vecs.push_back('{4'd6,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010});
        vecs.push_back('{4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100});
        vecs.push_back('{4'd7,  32'd5,        32'd4,        32'd1,        5'b00100});
        vecs.push_back('{4'd7,  32'd4,        32'd5,        32'hFFFFFFFF, 5'b01000});
        vecs.push_back('{4'd7,  32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b00110});
        vecs.push_back('{4'd0,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 5'b00000});
        vecs.push_back('{4'd1,  32'h0000000F, 32'h000000F0, 32'h000000FF, 5'b00000});
        vecs.push_back('{4'd2,  32'h000000FF, 32'h0000000F, 32'h000000F0, 5'b00000});
        vecs.push_back('{4'd3,  32'd0,        32'd0,        32'hFFFFFFFF, 5'b01000});
        vecs.push_back('{4'd4,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 5'b10000});
        vecs.push_back('{4'd5,  32'h12345678, 32'd0,        32'hEDCBA987, 5'b01000});
        vecs.push_back('{4'd8,  32'hFFFFFFFF, 32'd1,        32'd1,        5'b00000});
        vecs.push_back('{4'd8,  32'd1,        32'hFFFFFFFF, 32'd0,        5'b10000});
        vecs.push_back('{4'd12, 32'hFFFFFFFE, 32'd4,        32'hFFFFFFE0, 5'b01000});
        vecs.push_back('{4'd13, 32'hFFFFFFC0, 32'd35,       32'hFFFFFFF8, 5'b01000});
        vecs.push_back('{4'd15, 32'd5,        32'd3,        32'd0,        5'b00000});
`ifdef ALU_MULH_EN
        vecs.push_back('{4'd14, 32'hFFFFFFF9, 32'd6,        32'hFFFFFFFF, 5'b01000});
`else
        vecs.push_back('{4'd14, 32'd5,        32'd3,        32'd0,        5'b00000});
`endif
        vecs.push_back('{4'd9,  32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6, 5'b01000});
        vecs.push_back('{4'd9,  32'h00010000, 32'h00010000, 32'h00000000, 5'b10010});
        vecs.push_back('{4'd9,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b01010});
        vecs.push_back('{4'd10, 32'hFFFFFFF6, 32'd3,        32'hFFFFFFFD, 5'b01000});
        vecs.push_back('{4'd11, 32'hFFFFFFF6, 32'd3,        32'hFFFFFFFF, 5'b01000});
        vecs.push_back('{4'd10, 32'd10,       32'd0,        32'hFFFFFFFF, 5'b01001});
        vecs.push_back('{4'd11, 32'd10,       32'd0,        32'd10,       5'b00001});
        vecs.push_back('{4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 5'b01010});
        vecs.push_back('{4'd10, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 5'b01000});
        vecs.push_back('{4'd11, 32'd7,        32'hFFFFFFFE, 32'd1,        5'b00000});
        vecs.push_back('{4'd11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        5'b10000});

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back SUB then AND at one op per clock.
        in_valid = 1'b1; opcode = 4'd7; a = 32'd5; b = 32'd4;
        @(posedge clk);
        #1;
        opcode = 4'd0; a = 32'd1; b = 32'd0;
        @(negedge clk);
        check("b2b_sub", {29'd0, out_valid, carryout, in_ready, result}, {29'd0, 3'b111, 32'd1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_and", {29'd0, out_valid, zero, in_ready, result}, {29'd0, 3'b111, 32'd0});
        @(negedge clk);
        check("b2b_drain", {63'd0, out_valid}, 64'd0);

        // Output stall: result holds, nothing else is accepted.
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 4'd6; a = 32'd3; b = 32'd4;
        @(posedge clk);
        #1;
        opcode = 4'd7; a = 32'd100; b = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_cycle%0d", i), {30'd0, out_valid, in_ready, result},
                  {30'd0, 2'b10, 32'd7});
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("stall_release", {63'd0, out_valid}, 64'd0);

        // Reset ten cycles into a divide discards it.
        in_valid = 1'b1; opcode = 4'd10; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("div_busy_before_reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_state", {29'd0, out_valid, busy, in_ready, result}, {29'd0, 3'b001, 32'd0});
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_no_stale_result", 64'(seen), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
